// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and width default for the
// ALU sequencing stage.
package alu_ctrl_pkg;

  localparam int ALU_DATA_W = 8;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  // The ALU floats its output for the illegal opcode, so that code is never
  // allowed to reach it; a harmless add is issued instead.
  function automatic logic [1:0] safe_sel(input logic [1:0] op);
    return (op == OP_ILL) ? OP_ADD : op;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Request/capture sequencer around the combinational ALU: registers operands
// onto the ALU, captures its output after one settle cycle, holds the result.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_op,
  input  logic              in_use_acc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic              res_err,
  output logic [DATA_W-1:0] acc
);

  state_t            state_q;
  logic              in_ready_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [1:0]        alu_sel_q;
  logic              err_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_zero_q;
  logic              res_err_q;
  logic [DATA_W-1:0] acc_q;

  logic [DATA_W-1:0] cap_data_d;
  logic              cap_zero_d;

  // An illegal request never looks at alu_out: the result is forced to zero.
  always_comb begin
    cap_data_d = '0;
    cap_zero_d = 1'b1;
    if (!err_q) begin
      cap_data_d = alu_out;
      cap_zero_d = (alu_out == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= OP_ADD;
      err_q       <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            alu_a_q    <= in_use_acc ? acc_q : in_a;
            alu_b_q    <= in_b;
            alu_sel_q  <= safe_sel(in_op);
            err_q      <= (in_op == OP_ILL);
            in_ready_q <= 1'b0;
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_data_q  <= cap_data_d;
          res_zero_q  <= cap_zero_d;
          res_err_q   <= err_q;
          if (!err_q) begin
            acc_q <= alu_out;
          end
          res_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          // Results stay on the outputs after acceptance; only valid drops.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_err   = res_err_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU beside the DUT, directed scenarios
// plus randomized requests checked against an accumulator reference model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_op;
  logic       in_use_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_zero;
  logic       res_err;
  logic [7:0] acc;

  int vecs = 0;
  int errs = 0;
  logic [7:0] m_acc = 8'h00;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_err(res_err),
    .acc(acc)
  );

  function automatic logic [7:0] arith(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] la, lb;
    la = {4'h0, a[3:0]};
    lb = {4'h0, b[3:0]};
    case (op)
      2'b00:   return la * lb;
      2'b01:   return a + b;
      2'b10:   return a - b;
      default: return 8'h00;
    endcase
  endfunction

  // External ALU: floats its output for the illegal opcode.
  assign alu_out = (alu_sel == 2'b11) ? 8'hzz : arith(alu_sel, alu_a, alu_b);

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                      input logic ua, output bit ok);
    ok = 1'b0;
    in_a = a; in_b = b; in_op = op; in_use_acc = ua; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = 8'hA5; in_b = 8'h5A;
    in_op = 2'b01; in_use_acc = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    vecs++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin errs++;
      $display("FAIL reset_hs got ready=%b valid=%b want 1/0", in_ready, res_valid); end
    vecs++; if (res_data !== 8'h00 || res_zero !== 1'b0 || res_err !== 1'b0 || acc !== 8'h00) begin errs++;
      $display("FAIL reset_res got data=%h zero=%b err=%b acc=%h want 00/0/0/00", res_data, res_zero, res_err, acc); end
    vecs++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 2'b01) begin errs++;
      $display("FAIL reset_alu got a=%h b=%h sel=%b want 00/00/01", alu_a, alu_b, alu_sel); end
    rst_n = 1'b1;
    m_acc = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_add();
    bit ok;
    res_ready = 1'b1;
    send(8'hF0, 8'h20, 2'b01, 1'b0, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL add_accept got timeout want accept"); end
    vecs++; if (in_ready !== 1'b0 || res_valid !== 1'b0) begin errs++;
      $display("FAIL add_exec got ready=%b valid=%b want 0/0", in_ready, res_valid); end
    @(negedge clk);
    vecs++; if (res_valid !== 1'b1 || res_data !== 8'h10 || res_zero !== 1'b0 || acc !== 8'h10) begin errs++;
      $display("FAIL add_result got v=%b data=%h z=%b acc=%h want 1/10/0/10", res_valid, res_data, res_zero, acc); end
    @(negedge clk);
    vecs++; if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 8'h10) begin errs++;
      $display("FAIL add_return got ready=%b v=%b data=%h want 1/0/10", in_ready, res_valid, res_data); end
    res_ready = 1'b0;
    m_acc = 8'h10;
  endtask

  task automatic test_sub_chain();
    bit ok;
    send(8'h05, 8'h07, 2'b10, 1'b0, ok);
    @(negedge clk);
    vecs++; if (ok !== 1'b1 || res_data !== 8'hFE || res_zero !== 1'b0 || acc !== 8'hFE) begin errs++;
      $display("FAIL sub1 got ok=%b data=%h z=%b acc=%h want 1/FE/0/FE", ok, res_data, res_zero, acc); end
    release_result();
    send(8'h5A, 8'hFE, 2'b10, 1'b1, ok);
    vecs++; if (alu_a !== 8'hFE || alu_b !== 8'hFE || alu_sel !== 2'b10) begin errs++;
      $display("FAIL sub2_operands got a=%h b=%h sel=%b want FE/FE/10", alu_a, alu_b, alu_sel); end
    @(negedge clk);
    vecs++; if (ok !== 1'b1 || res_data !== 8'h00 || res_zero !== 1'b1 || acc !== 8'h00) begin errs++;
      $display("FAIL sub2 got ok=%b data=%h z=%b acc=%h want 1/00/1/00", ok, res_data, res_zero, acc); end
    release_result();
    m_acc = 8'h00;
  endtask

  task automatic test_mul_reset_hold();
    bit ok;
    send(8'h37, 8'h96, 2'b00, 1'b0, ok);
    @(negedge clk);
    vecs++; if (ok !== 1'b1 || res_valid !== 1'b1 || res_data !== 8'h2A || acc !== 8'h2A) begin errs++;
      $display("FAIL mul got ok=%b v=%b data=%h acc=%h want 1/1/2A/2A", ok, res_valid, res_data, acc); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++; if (res_valid !== 1'b0 || in_ready !== 1'b1 || acc !== 8'h00 || res_data !== 8'h00) begin errs++;
      $display("FAIL hold_reset got v=%b ready=%b acc=%h data=%h want 0/1/00/00", res_valid, in_ready, acc, res_data); end
    vecs++; if (alu_sel !== 2'b01 || alu_a !== 8'h00 || alu_b !== 8'h00) begin errs++;
      $display("FAIL hold_reset_alu got sel=%b a=%h b=%h want 01/00/00", alu_sel, alu_a, alu_b); end
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if (res_valid !== 1'b0) begin errs++;
      $display("FAIL hold_reset_drop got v=%b want 0", res_valid); end
    res_ready = 1'b0;
    m_acc = 8'h00;
  endtask

  task automatic test_illegal();
    bit ok;
    send(8'h08, 8'h08, 2'b01, 1'b0, ok);
    @(negedge clk);
    release_result();
    send(8'h33, 8'h44, 2'b11, 1'b0, ok);
    vecs++; if (ok !== 1'b1 || alu_sel !== 2'b01) begin errs++;
      $display("FAIL ill_sel got ok=%b sel=%b want 1/01", ok, alu_sel); end
    @(negedge clk);
    vecs++; if (res_err !== 1'b1 || res_data !== 8'h00 || res_zero !== 1'b1 || acc !== 8'h10) begin errs++;
      $display("FAIL ill_result got err=%b data=%h z=%b acc=%h want 1/00/1/10", res_err, res_data, res_zero, acc); end
    vecs++; if (alu_sel !== 2'b01) begin errs++;
      $display("FAIL ill_sel_hold got sel=%b want 01", alu_sel); end
    release_result();
    send(8'hEE, 8'h01, 2'b01, 1'b1, ok);
    @(negedge clk);
    vecs++; if (res_err !== 1'b0 || res_data !== 8'h11 || acc !== 8'h11) begin errs++;
      $display("FAIL ill_after got err=%b data=%h acc=%h want 0/11/11", res_err, res_data, acc); end
    release_result();
    m_acc = 8'h11;
  endtask

  task automatic test_backpressure();
    bit ok;
    send(8'h11, 8'h22, 2'b01, 1'b0, ok);
    @(negedge clk);
    in_a = 8'h44; in_b = 8'h01; in_op = 2'b01; in_use_acc = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vecs++; if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_data !== 8'h33 || acc !== 8'h33) begin errs++;
        $display("FAIL bp_hold cyc %0d got v=%b ready=%b data=%h acc=%h want 1/0/33/33", i, res_valid, in_ready, res_data, acc); end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    vecs++; if (in_ready !== 1'b1 || res_valid !== 1'b0 || alu_a !== 8'h11) begin errs++;
      $display("FAIL bp_release got ready=%b v=%b a=%h want 1/0/11", in_ready, res_valid, alu_a); end
    @(negedge clk);
    in_valid = 1'b0;
    vecs++; if (in_ready !== 1'b0 || alu_a !== 8'h44 || alu_b !== 8'h01) begin errs++;
      $display("FAIL bp_next_accept got ready=%b a=%h b=%h want 0/44/01", in_ready, alu_a, alu_b); end
    @(negedge clk);
    vecs++; if (res_valid !== 1'b1 || res_data !== 8'h45 || acc !== 8'h45) begin errs++;
      $display("FAIL bp_next_result got v=%b data=%h acc=%h want 1/45/45", res_valid, res_data, acc); end
    release_result();
    m_acc = 8'h45;
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] a, b, opa, exp_d;
    logic [1:0] op;
    logic ua;
    int d;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      ua = 1'($urandom); d = $urandom_range(0, 3);
      opa = ua ? m_acc : a;
      exp_d = (op == 2'b11) ? 8'h00 : arith(op, opa, b);
      send(a, b, op, ua, ok);
      vecs++; if (ok !== 1'b1 || alu_a !== opa || alu_b !== b || alu_sel !== ((op == 2'b11) ? 2'b01 : op)) begin errs++;
        $display("FAIL rnd_issue %0d got ok=%b a=%h b=%h sel=%b want a=%h b=%h op=%b", n, ok, alu_a, alu_b, alu_sel, opa, b, op); end
      @(negedge clk);
      if (op != 2'b11) m_acc = exp_d;
      vecs++; if (res_valid !== 1'b1 || res_data !== exp_d || res_zero !== (exp_d == 8'h00) ||
                  res_err !== (op == 2'b11) || acc !== m_acc) begin errs++;
        $display("FAIL rnd_result %0d got v=%b data=%h z=%b err=%b acc=%h want data=%h acc=%h op=%b",
                 n, res_valid, res_data, res_zero, res_err, acc, exp_d, m_acc, op); end
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        vecs++; if (res_valid !== 1'b1 || res_data !== exp_d || acc !== m_acc) begin errs++;
          $display("FAIL rnd_stall %0d got v=%b data=%h acc=%h want 1/%h/%h", n, res_valid, res_data, acc, exp_d, m_acc); end
      end
      release_result();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_sub_chain();
    test_mul_reset_hold();
    test_illegal();
    test_backpressure();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
